instr_fetch_unit: RTL and testbench

//  Instruction fetch front end that produces the op/funct3/funct7 stream consumed by the

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit_fifo.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 62 ++++++
 tb/tb_instr_fetch_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rv_fetch_pkg: shared widths, reset PC, fetch FSM states and decode field positions
package rv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;
  localparam int FIFO_DEPTH_DEF = 2;
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} fetch_state_e;
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory, redirect and decode-side signals of the fetch unit
interface instr_fetch_unit_if;
  import rv_fetch_pkg::*;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      dec_op;
  logic [2:0]      dec_funct3;
  logic [6:0]      dec_funct7;
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_op, dec_funct3, dec_funct7,
    input  imem_ack, imem_rdata, branch_taken, branch_target, dec_ready
  );
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_op, dec_funct3, dec_funct7,
    output imem_ack, imem_rdata, branch_taken, branch_target, dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} pairs; flush beats push in the same cycle
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty;
  // storage array, written only by an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
  // pointers and occupancy; reset and flush both empty the buffer
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + one-outstanding imem reads into a small buffer feeding decode
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  fetch_state_e      r_state;
  logic [XLEN-1:0]   r_fpc, r_hold_addr, w_target, w_instr;
  logic [2*XLEN-1:0] w_head;
  logic              w_empty, w_full, w_push, w_pop;
  // a request, once raised in REQ, can only be dropped by a push, so it stays up until ack
  assign bus.imem_req  = (r_state == REQ && !w_full) || r_state == FLUSH;
  assign bus.imem_addr = r_state == FLUSH ? r_hold_addr : r_fpc;
  assign w_push        = r_state == REQ && bus.imem_req && bus.imem_ack && !bus.branch_taken;
  assign w_pop         = bus.dec_valid && bus.dec_ready;
  assign w_target      = bus.branch_target & ~XLEN'(3);
  fetch_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.branch_taken),
    .i_data  ({r_fpc, bus.imem_rdata}),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
  assign w_instr        = w_empty ? '0 : w_head[XLEN-1:0];
  assign bus.dec_valid  = !w_empty;
  assign bus.dec_instr  = w_instr;
  assign bus.dec_pc     = w_empty ? '0 : w_head[2*XLEN-1:XLEN];
  assign bus.dec_op     = w_instr[OP_MSB:OP_LSB];
  assign bus.dec_funct3 = w_instr[F3_MSB:F3_LSB];
  assign bus.dec_funct7 = w_instr[F7_MSB:F7_LSB];
  // fetch FSM: redirect always wins the PC; a redirect under a pending read waits it out in FLUSH
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_fpc       <= RESET_PC;
      r_hold_addr <= RESET_PC;
    end else begin
      if (bus.branch_taken) r_fpc <= w_target;
      else if (w_push) r_fpc <= r_fpc + XLEN'(4);
      unique case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (bus.branch_taken && bus.imem_req && !bus.imem_ack) begin
            r_state     <= FLUSH;
            r_hold_addr <= r_fpc;
          end
        end
        FLUSH: if (bus.imem_ack) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed tests with an expected-PC scoreboard checked by a decode monitor
module tb_instr_fetch_unit;
  import rv_fetch_pkg::*;
  logic clk = 0;
  logic rst = 0;
  int lat = 0;
  int wcnt = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  instr_fetch_unit_if bus();
  instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h0 ? 32'h00500093 : {a[23:0], 8'h33};
  endfunction

  assign bus.imem_ack   = bus.imem_req && wcnt >= lat;
  assign bus.imem_rdata = memf(bus.imem_addr);
  always @(posedge clk) wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 1 : 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int l, input logic rdy);
    rst = 0;
    tick(2);
    lat = l;
    bus.dec_ready = rdy;
    bus.branch_taken = 0;
    rst = 1;
    tick();
  endtask

  task automatic finish_test();
    rst = 0;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e, w;
    if (rst && bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra got pc %h expected none", bus.dec_pc);
      end else begin
        e = exp_q.pop_front();
        w = memf(e);
        chk("sb_pc", bus.dec_pc, e);
        chk("sb_instr", bus.dec_instr, w);
        chk("sb_op", {25'd0, bus.dec_op}, {25'd0, w[6:0]});
        chk("sb_f3", {29'd0, bus.dec_funct3}, {29'd0, w[14:12]});
        chk("sb_f7", {25'd0, bus.dec_funct7}, {25'd0, w[31:25]});
      end
    end
  end

  initial begin
    bus.dec_ready = 1;
    bus.branch_taken = 0;
    bus.branch_target = '0;
    // reset state and first request
    tick(2);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("rst_pc", bus.dec_pc, 32'd0);
    chk("rst_instr", bus.dec_instr, 32'd0);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(4 * k));
    rst = 1;
    chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    // zero-wait streaming
    for (int k = 0; k < 6; k++) begin
      chk("stream_addr", bus.imem_addr, 32'(4 * k));
      if (k == 1) begin
        chk("first_pc", bus.dec_pc, 32'h0);
        chk("first_op", {25'd0, bus.dec_op}, 32'h13);
        chk("first_f3", {29'd0, bus.dec_funct3}, 32'h0);
        chk("first_f7", {25'd0, bus.dec_funct7}, 32'h0);
      end
      tick();
    end
    finish_test();
    // backpressure fills the buffer and stops requests
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    start(0, 0);
    tick(2);
    chk("full_req", {31'd0, bus.imem_req}, 32'd0);
    chk("full_valid", {31'd0, bus.dec_valid}, 32'd1);
    chk("full_pc", bus.dec_pc, 32'h0);
    tick();
    chk("hold_pc", bus.dec_pc, 32'h0);
    bus.dec_ready = 1;
    tick();
    chk("resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'h8);
    tick();
    finish_test();
    // redirect while a 3-cycle read is pending
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h100);
    start(2, 1);
    tick(6);
    chk("pend_addr", bus.imem_addr, 32'h8);
    bus.branch_taken = 1;
    bus.branch_target = 32'h100;
    tick();
    bus.branch_taken = 0;
    chk("flush_addr", bus.imem_addr, 32'h8);
    chk("flush_req", {31'd0, bus.imem_req}, 32'd1);
    chk("flush_valid", {31'd0, bus.dec_valid}, 32'd0);
    tick();
    chk("flush_addr2", bus.imem_addr, 32'h8);
    tick();
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_valid", {31'd0, bus.dec_valid}, 32'd0);
    tick(2);
    chk("redir_valid2", {31'd0, bus.dec_valid}, 32'd0);
    tick();
    chk("redir_valid3", {31'd0, bus.dec_valid}, 32'd1);
    tick();
    finish_test();
    // redirect in the ack cycle, unaligned target
    exp_q.push_back(32'h100);
    start(2, 1);
    tick(2);
    chk("ackbr_ack", {31'd0, bus.imem_ack}, 32'd1);
    bus.branch_taken = 1;
    bus.branch_target = 32'h102;
    tick();
    bus.branch_taken = 0;
    chk("ackbr_addr", bus.imem_addr, 32'h100);
    chk("ackbr_valid", {31'd0, bus.dec_valid}, 32'd0);
    tick(3);
    chk("ackbr_valid2", {31'd0, bus.dec_valid}, 32'd1);
    tick();
    finish_test();
    // PC wraps past the top of the address space
    exp_q.push_back(32'hFFFF_FFFC);
    start(0, 1);
    bus.branch_taken = 1;
    bus.branch_target = 32'hFFFF_FFFE;
    tick();
    bus.branch_taken = 0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'd0, bus.dec_valid}, 32'd0);
    tick();
    chk("wrap_addr2", bus.imem_addr, 32'h0);
    tick();
    finish_test();
    // reset while a read is outstanding
    start(2, 1);
    tick();
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd1);
    rst = 0;
    tick();
    chk("midrst_req0", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, bus.dec_valid}, 32'd0);
    rst = 1;
    tick();
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_req1", {31'd0, bus.imem_req}, 32'd1);
    finish_test();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
